// File: rtl/mcp_tx_buf_if.sv
// Local-side push port and remote-side MCP launch port of the buffered sender.
interface mcp_tx_buf_if #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH + 1);

    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [DW-1:0] tx_data;
    logic          tx_en;
    logic          tx_ack_tgl;
    logic [LW-1:0] level;
    logic          busy;
    logic          proto_err;
    logic          clr_err;

    // Driver side: upstream producer plus the remote acknowledger.
    modport master (
        output in_valid, in_data, tx_ack_tgl, clr_err,
        input  in_ready, tx_data, tx_en, level, busy, proto_err
    );

    // The buffer itself.
    modport slave (
        input  in_valid, in_data, tx_ack_tgl, clr_err,
        output in_ready, tx_data, tx_en, level, busy, proto_err
    );
endinterface

// File: rtl/mcp_tx_buf.sv
// Buffered send side of a multi-cycle-path CDC handshake. Words queue in a
// DEPTH-entry FIFO; one at a time is launched as a held data bus plus a toggle
// enable, and the next launch waits for the synchronized remote toggle ack.
module mcp_tx_buf #(
    parameter int DW          = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    mcp_tx_buf_if.slave      bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    typedef enum logic {IDLE, WAIT_ACK} state_t;

    state_t                 state;
    logic [DW-1:0]          mem [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [LW-1:0]          level_q;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_prev;
    logic                   ack_s, ack_edge;
    logic                   push, pop;
    logic [DW-1:0]          tx_data_q;
    logic                   tx_en_q, busy_q, err_q;

    assign ack_s    = ack_sync[SYNC_STAGES-1];
    assign ack_edge = ack_s ^ ack_prev;

    // No ready-through-pop: a full FIFO refuses even when it is popping.
    assign push = bus.in_valid && (level_q != FULL);

    // A word leaves the FIFO whenever the sender is free to launch: idle, or
    // just acknowledged (back-to-back launch on the ack cycle).
    assign pop = (level_q != '0) && ((state == IDLE) || ack_edge);

    assign bus.in_ready  = (level_q != FULL);
    assign bus.level     = level_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_en     = tx_en_q;
    assign bus.busy      = busy_q;
    assign bus.proto_err = err_q;

    // Ack synchronizer chain plus the previous-value flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_sync <= '0;
            ack_prev <= 1'b0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.tx_ack_tgl};
            ack_prev <= ack_s;
        end
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.in_data;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Launch FSM with registered outputs; the error flag is sticky and a new
    // error wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx_data_q <= '0;
            tx_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (bus.clr_err)
                err_q <= 1'b0;
            if (pop) begin
                tx_data_q <= mem[rd_ptr];
                tx_en_q   <= ~tx_en_q;
            end
            case (state)
                IDLE: begin
                    if (ack_edge)
                        err_q <= 1'b1;
                    if (pop) begin
                        state  <= WAIT_ACK;
                        busy_q <= 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (ack_edge && !pop) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mcp_tx_buf.sv
// Directed bench for mcp_tx_buf: launch latency, fill/backpressure, ordered
// drain on acks, push+pop, protocol error, and mid-operation reset.
module tb_mcp_tx_buf;
    localparam int DW = 8;
    localparam int DEPTH = 4;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    logic exp_en = 1'b0;

    mcp_tx_buf_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

    mcp_tx_buf #(.DW(DW), .DEPTH(DEPTH), .SYNC_STAGES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Toggle the remote ack and check the next word launches exactly S+1 edges later.
    task automatic ack_launch(input string tag, input logic [7:0] exp_word, input logic [7:0] old_word);
        bus.tx_ack_tgl = ~bus.tx_ack_tgl;
        repeat (S) step();
        chk({tag, "_hold"}, bus.tx_data, old_word);
        chk({tag, "_en_hold"}, bus.tx_en, exp_en);
        step();
        exp_en = ~exp_en;
        chk({tag, "_data"}, bus.tx_data, exp_word);
        chk({tag, "_en"}, bus.tx_en, exp_en);
    endtask

    // Final ack with nothing queued returns the sender to idle.
    task automatic ack_idle(input string tag);
        bus.tx_ack_tgl = ~bus.tx_ack_tgl;
        repeat (S + 1) step();
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_en"}, bus.tx_en, exp_en);
    endtask

    task automatic push(input logic [7:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] words [4];
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.tx_ack_tgl = 1'b0;
        bus.clr_err    = 1'b0;
        words = '{8'h22, 8'h33, 8'h44, 8'h55};

        // Reset values
        step(); step();
        rst = 1'b0;
        chk("rst_data", bus.tx_data, 0);
        chk("rst_en", bus.tx_en, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.proto_err, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_ready", bus.in_ready, 1);

        // Single word: pushed at N, launched at N+1
        push(8'hA5);
        chk("a5_level_n", bus.level, 1);
        chk("a5_en_n", bus.tx_en, 0);
        step();
        exp_en = 1'b1;
        chk("a5_data", bus.tx_data, 8'hA5);
        chk("a5_en", bus.tx_en, 1);
        chk("a5_busy", bus.busy, 1);
        chk("a5_level", bus.level, 0);
        ack_idle("a5_done");

        // Fill: 0x11 launches, 0x22..0x55 queue, 0x66 is back-pressured
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = 8'h11 * (i + 1);
            step();
        end
        exp_en = ~exp_en;
        chk("fill_launch", bus.tx_data, 8'h11);
        chk("fill_level", bus.level, 4);
        chk("fill_ready", bus.in_ready, 0);
        bus.in_data = 8'h66;
        step();
        chk("fill_hold_level", bus.level, 4);
        chk("fill_hold_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;

        // Drain in order, one launch per ack
        for (int i = 0; i < 4; i++) begin
            ack_launch($sformatf("drain%0d", i), words[i], (i == 0) ? 8'h11 : words[i-1]);
            step(); step();
        end
        chk("drain_level", bus.level, 0);
        ack_idle("drain_done");

        // Push and launch in the same cycle at level 2
        push(8'h61);
        push(8'h62);
        exp_en = ~exp_en;
        chk("pp_first", bus.tx_data, 8'h61);
        push(8'h63);
        chk("pp_level2", bus.level, 2);
        bus.tx_ack_tgl = ~bus.tx_ack_tgl;
        repeat (S) step();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h64;
        step();
        bus.in_valid = 1'b0;
        exp_en = ~exp_en;
        chk("pp_level_same", bus.level, 2);
        chk("pp_launch", bus.tx_data, 8'h62);
        ack_launch("pp_b", 8'h63, 8'h62);
        ack_launch("pp_c", 8'h64, 8'h63);
        ack_idle("pp_done");

        // Ack while idle: sticky error, clear, and set-beats-clear
        bus.tx_ack_tgl = ~bus.tx_ack_tgl;
        repeat (S) step();
        chk("err_early", bus.proto_err, 0);
        step();
        chk("err_set", bus.proto_err, 1);
        chk("err_no_en", bus.tx_en, exp_en);
        step();
        chk("err_sticky", bus.proto_err, 1);
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
        chk("err_clr", bus.proto_err, 0);
        bus.tx_ack_tgl = ~bus.tx_ack_tgl;
        repeat (S) step();
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
        chk("err_set_wins", bus.proto_err, 1);
        bus.clr_err = 1'b1;
        step();
        bus.clr_err = 1'b0;
        chk("err_clr2", bus.proto_err, 0);

        // Reset while busy with level 3
        push(8'h71);
        push(8'h72);
        push(8'h73);
        push(8'h74);
        chk("mid_busy", bus.busy, 1);
        chk("mid_level", bus.level, 3);
        rst = 1'b1;
        bus.tx_ack_tgl = 1'b0;
        step();
        rst = 1'b0;
        exp_en = 1'b0;
        chk("mrst_en", bus.tx_en, 0);
        chk("mrst_data", bus.tx_data, 0);
        chk("mrst_level", bus.level, 0);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_ready", bus.in_ready, 1);
        push(8'h7E);
        chk("post_en_n", bus.tx_en, 0);
        step();
        chk("post_data", bus.tx_data, 8'h7E);
        chk("post_en", bus.tx_en, 1);
        chk("post_busy", bus.busy, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "timeout");
    end
endmodule
